// File: rtl/mul_cell_seq_pkg.sv
// rtl/mul_cell_seq_pkg.sv - shared types and constants for the sequential 32x32 multiplier (MUL_CELL_SEQ_MULX_EN)
package mul_cell_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Partial-product select; the value doubles as the issue order
  typedef enum logic [1:0] {
    PP0 = 2'd0,  // Alo * Blo
    PP1 = 2'd1,  // Alo * Bhi
    PP2 = 2'd2,  // Ahi * Blo
    PP3 = 2'd3   // Ahi * Bhi
  } pp_sel_t;

  // Legal pipeline depth of the 16x16 cell
  localparam int MULT_LAT_MIN = 1;
  localparam int MULT_LAT_MAX = 3;

  // Left shift applied to a partial product before accumulation
  function automatic logic [5:0] pp_shift(pp_sel_t s);
    case (s)
      PP0:     pp_shift = 6'd0;
      PP3:     pp_shift = 6'd32;
      default: pp_shift = 6'd16;
    endcase
  endfunction

  // True when the partial product uses the upper half of A
  function automatic logic pp_a_hi(pp_sel_t s);
    pp_a_hi = (s == PP2) || (s == PP3);
  endfunction

  // True when the partial product uses the upper half of B
  function automatic logic pp_b_hi(pp_sel_t s);
    pp_b_hi = (s == PP1) || (s == PP3);
  endfunction

endpackage

// File: rtl/mul_cell_seq_if.sv
// rtl/mul_cell_seq_if.sv - operand/result handshake bundle for mul_cell_seq (MUL_CELL_SEQ_MULX_EN)
interface mul_cell_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        op_high;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        busy;

  // Requester side: supplies operands, consumes results
  modport master (
    output in_valid, src1, src2, op_high, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, src1, src2, op_high, out_ready,
    output in_ready, out_valid, result_lo, result_hi, busy
  );
endinterface

// File: rtl/mul_cell_seq_mult16.sv
// rtl/mul_cell_seq_mult16.sv - registered 16x16->32 unsigned multiplier cell with LAT stages (MUL_CELL_SEQ_MULX_EN)
module mul_cell_seq_mult16 #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  logic [31:0] stage_q [LAT];

  // Product pipeline: advances only while enabled, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= {16'd0, a_i} * {16'd0, b_i};
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign p_o = stage_q[LAT-1];

endmodule

// File: rtl/mul_cell_seq.sv
// rtl/mul_cell_seq.sv - 32x32 multiplier time-sharing one 16x16 cell; MUL_CELL_SEQ_MULX_EN enables the 64-bit product
module mul_cell_seq
  import mul_cell_seq_pkg::*;
#(
  parameter int MULT_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mul_cell_seq_if.slave bus
);

  if (MULT_LAT < MULT_LAT_MIN || MULT_LAT > MULT_LAT_MAX) begin : g_bad_lat
    $error("mul_cell_seq: MULT_LAT out of range");
  end

`ifdef MUL_CELL_SEQ_MULX_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif

  localparam logic [1:0] DRAIN_LAST = 2'(MULT_LAT);

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  logic             accept;
  logic             cell_en;
  pp_sel_t          cur_sel;
  pp_sel_t          last_sel;
  logic [15:0]      cell_a;
  logic [15:0]      cell_b;
  logic [31:0]      prod;

  // Tags travelling alongside the cell pipeline so each product knows its weight
  logic [MULT_LAT-1:0] tag_vld_q;
  pp_sel_t             tag_sel_q [MULT_LAT];

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign cell_en = (state_q == ISSUE) || (state_q == DRAIN);
  assign cur_sel = pp_sel_t'(cnt_q);
  assign cell_a  = pp_a_hi(cur_sel) ? a_q[31:16] : a_q[15:0];
  assign cell_b  = pp_b_hi(cur_sel) ? b_q[31:16] : b_q[15:0];

`ifdef MUL_CELL_SEQ_MULX_EN
  logic op_high_q;

  // The 64-bit request is latched with the operands and governs P3 and result_hi
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       op_high_q <= 1'b0;
    else if (accept) op_high_q <= bus.op_high;
  end

  assign last_sel      = op_high_q ? PP3 : PP2;
  assign bus.result_hi = op_high_q ? acc_q[63:32] : 32'd0;
`else
  logic unused_op_high;
  assign unused_op_high = bus.op_high;
  assign last_sel       = PP2;
  assign bus.result_hi  = 32'd0;
`endif

  // Controller: issue sequencing, drain count and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.src1;
            b_q        <= bus.src2;
            cnt_q      <= 2'd0;
            state_q    <= ISSUE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ISSUE: begin
          if (cur_sel == last_sel) begin
            cnt_q   <= 2'd0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q       <= 2'd0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mul_cell_seq_mult16 #(
    .LAT(MULT_LAT)
  ) u_cell (
    .clk  (clk),
    .rst  (reset),
    .en_i (cell_en),
    .a_i  (cell_a),
    .b_i  (cell_b),
    .p_o  (prod)
  );

  // Tag pipeline mirrors the cell so the accumulator knows when and how far to shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) tag_sel_q[i] <= PP0;
    end else if (cell_en) begin
      tag_vld_q[0] <= (state_q == ISSUE);
      tag_sel_q[0] <= cur_sel;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_sel_q[i] <= tag_sel_q[i-1];
      end
    end
  end

  // Weighted partial product added to the running sum
  always_comb begin
    acc_d = acc_q + ACC_W'({32'd0, prod} << pp_shift(tag_sel_q[MULT_LAT-1]));
  end

  // Accumulator: cleared on accept, updated as each tagged product leaves the cell
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     acc_q <= '0;
    else if (accept)                               acc_q <= '0;
    else if (cell_en && tag_vld_q[MULT_LAT-1])     acc_q <= acc_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result_lo = acc_q[31:0];

endmodule

// File: tb/tb_mul_cell_seq.sv
// tb/tb_mul_cell_seq.sv - self-checking bench for mul_cell_seq (honours MUL_CELL_SEQ_MULX_EN)
module tb_mul_cell_seq;

  localparam int L = 1;
`ifdef MUL_CELL_SEQ_MULX_EN
  localparam bit MULX = 1'b1;
`else
  localparam bit MULX = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_cell_seq_if bus();

  mul_cell_seq #(.MULT_LAT(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int acc_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: number of partial products for a request
  function automatic int ref_n(input logic op);
    return (MULX && op) ? 4 : 3;
  endfunction

  // Reference: {result_hi, result_lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    if (!(MULX && op)) full[63:32] = 32'd0;
    return full;
  endfunction

  // Present operands at a negedge, check acceptance, leave at the negedge after the accept edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.src1     = a;
    bus.src2     = b;
    bus.op_high  = op;
    bus.in_valid = 1'b1;
    chk("accept_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    acc_edge     = edge_cnt;
    bus.in_valid = 1'b0;
    bus.src1     = $urandom;
    bus.src2     = $urandom;
    bus.op_high  = ~op;
  endtask

  // Wait (bounded) for out_valid, then check latency and both result words
  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op);
    int lat;
    logic [63:0] exp;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.out_valid === 1'b1) begin
        lat = edge_cnt - acc_edge;
        break;
      end
      @(negedge clk);
    end
    exp = ref_prod(a, b, op);
    if (lat < 0) chk({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
    else begin
      chk({tag, "_latency"}, 64'(lat), 64'(ref_n(op) + L + 1));
      chk({tag, "_lo"}, 64'(bus.result_lo), 64'(exp[31:0]));
      chk({tag, "_hi"}, 64'(bus.result_hi), 64'(exp[63:32]));
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        op;
    logic [63:0] exp;
    int          prev_edge;
    int          prev_n;

    bus.in_valid  = 1'b0;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    bus.op_high   = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    // Outputs while reset is held
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Directed low-word product
    start_op(32'h0001_0003, 32'h0002_0005, 1'b0);
    check_result("dir_basic", 32'h0001_0003, 32'h0002_0005, 1'b0);
    chk("dir_basic_lo_const", 64'(bus.result_lo), 64'h0000_0000_000B_000F);
    @(negedge clk);
    chk("after_hs_in_ready", 64'(bus.in_ready), 64'd1);
    chk("after_hs_out_valid", 64'(bus.out_valid), 64'd0);

    // All-ones operands with the high word requested
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_result("dir_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
`ifdef MUL_CELL_SEQ_MULX_EN
    chk("dir_ones_hi_const", 64'(bus.result_hi), 64'h0000_0000_FFFF_FFFE);
    chk("dir_ones_lo_const", 64'(bus.result_lo), 64'h0000_0000_0000_0001);
`else
    chk("dir_ones_hi_zero", 64'(bus.result_hi), 64'd0);
    chk("dir_ones_lo_const", 64'(bus.result_lo), 64'h0000_0000_0000_0001);
`endif
    @(negedge clk);

    // Consumer stall in DONE with an extra request presented
    a = $urandom; b = $urandom; op = 1'b1;
    exp = ref_prod(a, b, op);
    bus.out_ready = 1'b0;
    start_op(a, b, op);
    check_result("stall", a, b, op);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.src1     = $urandom;
      bus.src2     = $urandom;
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_lo", 64'(bus.result_lo), 64'(exp[31:0]));
      chk("stall_hi", 64'(bus.result_hi), 64'(exp[63:32]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_rel_out_valid", 64'(bus.out_valid), 64'd0);
    chk("stall_rel_in_ready", 64'(bus.in_ready), 64'd1);
    chk("stall_rel_busy", 64'(bus.busy), 64'd0);

    // Reset while P1 is being issued
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_lo", 64'(bus.result_lo), 64'd0);
    chk("midrst_hi", 64'(bus.result_hi), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_discard_out_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("midrst_idle_busy", 64'(bus.busy), 64'd0);
    start_op(32'd7, 32'd6, 1'b0);
    check_result("post_rst", 32'd7, 32'd6, 1'b0);
    chk("post_rst_lo_const", 64'(bus.result_lo), 64'd42);
    @(negedge clk);

    // Random back-to-back traffic with the consumer always ready
    prev_edge = 0;
    prev_n    = 0;
    for (int i = 0; i < 1000; i++) begin
      a  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      b  = (i % 11 == 0) ? 32'd0 : ((i % 13 == 0) ? 32'hFFFF_FFFF : $urandom);
      op = 1'($urandom_range(0, 1));
      start_op(a, b, op);
      if (i > 0) chk("rand_gap", 64'(acc_edge - prev_edge - 1), 64'(prev_n + L + 2));
      check_result("rand", a, b, op);
      @(negedge clk);
      prev_edge = acc_edge;
      prev_n    = ref_n(op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
